data_capture_arbiter: RTL

DATA_CAPTURE_ARBITER -- requirements
Module: data_capture_arbiter

---
 rtl/data_capture_arbiter_pkg.sv | 16 +
 rtl/data_capture_arbiter_if.sv | 34 +++
 rtl/data_capture_arbiter_rr_arbiter2.sv | 20 ++
 rtl/data_capture_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/data_capture_arbiter_pkg.sv
// Shared definitions for the data capture arbiter: FSM encoding and default
// burst geometry used by the interface and the top level.
package data_capture_arbiter_pkg;

  // Default burst geometry: words per burst and bits per word.
  localparam int DEF_CYCLES = 8;
  localparam int DEF_WIDTH  = 16;

  // Capture FSM encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage : data_capture_arbiter_pkg

// File: rtl/data_capture_arbiter_if.sv
// Bundle of the requester handshake and capture result signals.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface data_capture_arbiter_if
  import data_capture_arbiter_pkg::*;
#(
  parameter int CYCLES = DEF_CYCLES,
  parameter int WIDTH  = DEF_WIDTH
) ();

  localparam int IDX_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [1:0]              req;
  logic [1:0]              valid;
  logic [WIDTH-1:0]        data0;
  logic [WIDTH-1:0]        data1;
  logic                    abort;
  logic [1:0]              grant;
  logic                    busy;
  logic                    done;
  logic                    done_id;
  logic [IDX_W-1:0]        word_idx;
  logic [CYCLES*WIDTH-1:0] buffer;

  modport slave (
    input  req, valid, data0, data1, abort,
    output grant, busy, done, done_id, word_idx, buffer
  );

  modport master (
    output req, valid, data0, data1, abort,
    input  grant, busy, done, done_id, word_idx, buffer
  );

endinterface : data_capture_arbiter_if

// File: rtl/data_capture_arbiter_rr_arbiter2.sv
// Two-way round-robin selector. A lone requester wins outright; on a tie the
// requester that was not served last wins. Purely combinational.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] winner
);

  // Pick the one-hot winner from the request vector and last-served index.
  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule : rr_arbiter2

// File: rtl/data_capture_arbiter.sv
// Burst capture arbiter: grants one of two requesters, captures CYCLES words
// from the granted requester into a wide buffer, then pulses done for a cycle.
// Abort in CAPTURE drops the burst without a done pulse.
module data_capture_arbiter
  import data_capture_arbiter_pkg::*;
#(
  parameter int CYCLES = DEF_CYCLES,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  data_capture_arbiter_if.slave bus
);

  localparam int                 IDX_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(CYCLES - 1);

  state_t                  state_reg,    state_next;
  logic [1:0]              grant_reg,    grant_next;
  logic                    last_reg,     last_next;
  logic [IDX_W-1:0]        word_idx_reg, word_idx_next;
  logic [CYCLES*WIDTH-1:0] buffer_reg,   buffer_next;
  logic                    done_reg,     done_next;
  logic                    done_id_reg,  done_id_next;
  logic                    busy_reg,     busy_next;

  logic [1:0]              win;
  logic                    gnt_idx;
  logic                    gnt_valid;
  logic [WIDTH-1:0]        gnt_word;

  rr_arbiter2 u_rr (
    .req    (bus.req),
    .last   (last_reg),
    .winner (win)
  );

  // The granted index is the upper bit of the one-hot grant; only that
  // requester's valid and data are looked at during a burst.
  assign gnt_idx   = grant_reg[1];
  assign gnt_valid = bus.valid[gnt_idx];
  assign gnt_word  = gnt_idx ? bus.data1 : bus.data0;

  // Next-state, grant, buffer and status logic of the capture FSM.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    last_next     = last_reg;
    word_idx_next = word_idx_reg;
    buffer_next   = buffer_reg;
    done_next     = 1'b0;
    done_id_next  = done_id_reg;

    case (state_reg)
      IDLE: begin
        // Abort has no meaning here; only requests move the FSM.
        if (bus.req != 2'b00) begin
          grant_next    = win;
          last_next     = win[1];
          word_idx_next = '0;
          state_next    = CAPTURE;
        end
      end

      CAPTURE: begin
        // Abort beats a simultaneous valid word: nothing is written.
        if (bus.abort) begin
          grant_next = 2'b00;
          state_next = IDLE;
        end else if (gnt_valid) begin
          buffer_next[word_idx_reg*WIDTH +: WIDTH] = gnt_word;
          if (word_idx_reg == LAST_IDX) begin
            state_next    = DONE;
            grant_next    = 2'b00;
            word_idx_next = '0;
            done_id_next  = gnt_idx;
            done_next     = 1'b1;
          end else begin
            word_idx_next = word_idx_reg + IDX_W'(1);
          end
        end
      end

      DONE: begin
        // Pending requests are taken from IDLE, never straight from DONE.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        grant_next = 2'b00;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // State and output registers; reset clears everything and points the
  // last-served pointer at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      grant_reg    <= 2'b00;
      last_reg     <= 1'b1;
      word_idx_reg <= '0;
      buffer_reg   <= '0;
      done_reg     <= 1'b0;
      done_id_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      last_reg     <= last_next;
      word_idx_reg <= word_idx_next;
      buffer_reg   <= buffer_next;
      done_reg     <= done_next;
      done_id_reg  <= done_id_next;
      busy_reg     <= busy_next;
    end
  end

  assign bus.grant    = grant_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.done_id  = done_id_reg;
  assign bus.word_idx = word_idx_reg;
  assign bus.buffer   = buffer_reg;

endmodule : data_capture_arbiter
